// File: rtl/otter_pkg.sv
// Shared OTTER definitions: interrupt sequencer states and machine-mode CSR addresses.
// The CSR file imports the same address constants.
package otter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    REQ  = 2'd2
  } intr_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

endpackage

// File: rtl/otter_intr_ctrl_if.sv
// Signals between the interrupt sequencer, the main control FSM and the CSR file.
// The master side is the control FSM/CSR file; the slave side is otter_intr_ctrl.
interface otter_intr_ctrl_if;
  logic        csr_mie;
  logic        csr_mstatus;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        instr_boundary;
  logic        mret_exec;
  logic        trap_ack;
  logic        trap_req;
  logic        int_taken;
  logic        int_ret;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;

  modport master (
    output csr_mie, csr_mstatus, csr_mtvec, csr_mepc,
    output instr_boundary, mret_exec, trap_ack,
    input  trap_req, int_taken, int_ret, pc_redirect, pc_redirect_addr
  );

  modport slave (
    input  csr_mie, csr_mstatus, csr_mtvec, csr_mepc,
    input  instr_boundary, mret_exec, trap_ack,
    output trap_req, int_taken, int_ret, pc_redirect, pc_redirect_addr
  );
endinterface

// File: rtl/otter_intr_ctrl_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level input, followed by a
// one-cycle rising-edge pulse on the synchronised level.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // Fewer than two flops would not give metastability protection.
  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync;
  logic         sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[N-2:0], din};
      sync_d <= sync[N-1];
    end
  end

  assign rise = sync[N-1] & ~sync_d;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Interrupt sequencer for the multicycle OTTER core: latches external requests,
// raises a trap at an instruction boundary, and drives CSR strobes and PC redirect.
module otter_intr_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_in,
  otter_intr_ctrl_if.slave bus,
  output logic             irq_pending,
  output logic [CNT_W-1:0] irq_count
);

  import otter_pkg::*;

  intr_state_t state, state_next;
  logic        irq_edge;
  logic        take;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_in),
    .rise (irq_edge)
  );

  assign take = (state == REQ) && bus.trap_ack;

  // Clearing wins over a same-cycle edge; an edge while pending is absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pending <= 1'b0;
    end else if (take || !bus.csr_mie) begin
      irq_pending <= 1'b0;
    end else if (irq_edge) begin
      irq_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_count <= '0;
    end else if (take && (irq_count != '1)) begin
      irq_count <= irq_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A trap_ack in REQ pre-empts a simultaneous mret; REQ ignores enable changes.
  always_comb begin
    state_next           = state;
    bus.trap_req         = 1'b0;
    bus.int_taken        = 1'b0;
    bus.int_ret          = 1'b0;
    bus.pc_redirect      = 1'b0;
    bus.pc_redirect_addr = '0;

    unique case (state)
      IDLE: begin
        if (irq_pending) state_next = PEND;
      end
      PEND: begin
        if (!irq_pending) begin
          state_next = IDLE;
        end else if (bus.instr_boundary && bus.csr_mie && bus.csr_mstatus) begin
          state_next = REQ;
        end
      end
      REQ: begin
        bus.trap_req = 1'b1;
        if (bus.trap_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      bus.int_taken        = 1'b1;
      bus.pc_redirect      = 1'b1;
      bus.pc_redirect_addr = bus.csr_mtvec;
    end else if (bus.mret_exec) begin
      bus.int_ret          = 1'b1;
      bus.pc_redirect      = 1'b1;
      bus.pc_redirect_addr = bus.csr_mepc;
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl with a strobe scoreboard (CNT_W=2 to reach saturation).
module tb_otter_intr_ctrl;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq_in;
  logic          irq_pending;
  logic [CW-1:0] irq_count;

  otter_intr_ctrl_if bus ();

  otter_intr_ctrl #(
    .SYNC_STAGES (2),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .bus         (bus.slave),
    .irq_pending (irq_pending),
    .irq_count   (irq_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic        ret;
    logic        redir;
    logic [31:0] addr;
  } strobe_t;

  strobe_t sb_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the current strobe outputs with the oldest scoreboard entry.
  task automatic check_strobe(input string tag);
    strobe_t o, e;
    #1;
    o = '{bus.int_taken, bus.int_ret, bus.pc_redirect, bus.pc_redirect_addr};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, o);
    end else begin
      e = sb_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic pulse_irq();
    irq_in = 1'b1;
    tick();
    tick();
    irq_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_trap_req(input string tag);
    int unsigned n = 0;
    while (bus.trap_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, {31'd0, bus.trap_req}, 32'd1);
  endtask

  task automatic ack_trap(input string tag, input logic [31:0] vec);
    bus.trap_ack = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 1'b1, vec});
    check_strobe(tag);
    tick();
    bus.trap_ack = 1'b0;
  endtask

  task automatic take_irq(input string tag);
    pulse_irq();
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    wait_trap_req({tag, "_req"});
    ack_trap({tag, "_ack"}, bus.csr_mtvec);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    irq_in             = 1'b0;
    bus.csr_mie        = 1'b0;
    bus.csr_mstatus    = 1'b0;
    bus.csr_mtvec      = 32'h0;
    bus.csr_mepc       = 32'h0;
    bus.instr_boundary = 1'b0;
    bus.mret_exec      = 1'b0;
    bus.trap_ack       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_trap_req", {31'd0, bus.trap_req}, 32'd0);
    check("rst_pending", {31'd0, irq_pending}, 32'd0);
    check("rst_count", {30'd0, irq_count}, 32'd0);
    check("rst_redir_addr", bus.pc_redirect_addr, 32'd0);
    rst = 1'b0;

    // Basic trap
    bus.csr_mie     = 1'b1;
    bus.csr_mstatus = 1'b1;
    bus.csr_mtvec   = 32'h100;
    irq_in          = 1'b1;
    tick();
    tick();
    check("basic_pend_c2", {31'd0, irq_pending}, 32'd0);
    tick();
    check("basic_pend_c3", {31'd0, irq_pending}, 32'd1);
    tick();
    tick();
    bus.instr_boundary = 1'b1;
    #1;
    check("basic_no_req_at_bnd", {31'd0, bus.trap_req}, 32'd0);
    tick();
    bus.instr_boundary = 1'b0;
    check("basic_req", {31'd0, bus.trap_req}, 32'd1);
    ack_trap("basic_ack", 32'h100);
    check("basic_req_drop", {31'd0, bus.trap_req}, 32'd0);
    check("basic_pend_clr", {31'd0, irq_pending}, 32'd0);
    check("basic_count", {30'd0, irq_count}, 32'd1);
    irq_in = 1'b0;
    tick();
    tick();

    // Masked
    bus.csr_mie = 1'b0;
    irq_in      = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mask_pend", {31'd0, irq_pending}, 32'd0);
    bus.csr_mie = 1'b1;
    bus.instr_boundary = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.instr_boundary = 1'b0;
    check("mask_pend_late", {31'd0, irq_pending}, 32'd0);
    check("mask_no_req", {31'd0, bus.trap_req}, 32'd0);
    irq_in = 1'b0;
    tick();
    tick();

    // Global disable, then mret re-enables
    bus.csr_mstatus = 1'b0;
    bus.csr_mepc    = 32'h2C;
    pulse_irq();
    check("gdis_pend", {31'd0, irq_pending}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.instr_boundary = 1'b1;
      tick();
      bus.instr_boundary = 1'b0;
      tick();
      check("gdis_no_req", {31'd0, bus.trap_req}, 32'd0);
    end
    bus.mret_exec      = 1'b1;
    bus.instr_boundary = 1'b1;
    sb_q.push_back('{1'b0, 1'b1, 1'b1, 32'h2C});
    check_strobe("gdis_mret");
    tick();
    bus.mret_exec      = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.csr_mstatus    = 1'b1;
    check("gdis_no_req_mret", {31'd0, bus.trap_req}, 32'd0);
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("gdis_req", {31'd0, bus.trap_req}, 32'd1);
    ack_trap("gdis_ack", 32'h100);
    check("gdis_count", {30'd0, irq_count}, 32'd2);

    // Duplicate edges before a boundary
    do_reset();
    pulse_irq();
    pulse_irq();
    check("dup_pend", {31'd0, irq_pending}, 32'd1);
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    wait_trap_req("dup_req");
    ack_trap("dup_ack", 32'h100);
    bus.instr_boundary = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.instr_boundary = 1'b0;
    check("dup_no_second_req", {31'd0, bus.trap_req}, 32'd0);
    check("dup_count", {30'd0, irq_count}, 32'd1);

    // Reset while in REQ
    pulse_irq();
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    wait_trap_req("rreq_req");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rreq_trap_req", {31'd0, bus.trap_req}, 32'd0);
    check("rreq_pend", {31'd0, irq_pending}, 32'd0);
    bus.trap_ack = 1'b1;
    sb_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
    check_strobe("rreq_late_ack");
    tick();
    bus.trap_ack = 1'b0;

    // Counter saturation at CNT_W=2
    do_reset();
    bus.csr_mtvec = 32'h240;
    for (int i = 0; i < 5; i++) take_irq("sat");
    check("sat_count", {30'd0, irq_count}, 32'd3);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
